// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-SRAM line bridge.
// The watchdog is built only when WB_SRAM_BRIDGE_TIMEOUT_EN is defined.
package wb_bridge_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      ERR
   } state_t;

   // First lane at or above 'from' with a nonzero byte-enable nibble.
   // Returns LANES when no such lane exists.
   function automatic logic [2:0] next_lane(
      input logic [4*LANES-1:0] sel,
      input logic [2:0]         from
   );
      logic [2:0] r;
      r = 3'(LANES);
      for (int i = LANES - 1; i >= 0; i--) begin
         if (3'(i) >= from && sel[4*i +: 4] != 4'h0)
            r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/bridge_watchdog.sv
// Stall watchdog for the SRAM bridge; only present when
// WB_SRAM_BRIDGE_TIMEOUT_EN is defined.
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
module bridge_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic clear,
   output logic timeout
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   // Fires on the LIMIT-th consecutive cycle without progress.
   assign timeout = active && !clear && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (!active || clear)
         cnt <= '0;
      else if (!timeout)
         cnt <= cnt + W'(1);
   end

endmodule
`endif

// File: rtl/wb_sram_bridge.sv
// Wishbone B4 classic 128-bit slave to 32-bit SRAM bridge, serial beats.
// Optional watchdog: define WB_SRAM_BRIDGE_TIMEOUT_EN.
module wb_sram_bridge
   import wb_bridge_pkg::*;
#(
   parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
   parameter int          MEM_WORDS      = 16384,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  wb_adr_i,
   input  logic [127:0]                 wb_dat_i,
   output logic [127:0]                 wb_dat_o,
   input  logic                         wb_we_i,
   input  logic [15:0]                  wb_sel_i,
   input  logic                         wb_stb_i,
   input  logic                         wb_cyc_i,
   output logic                         wb_ack_o,
   output logic                         wb_err_o,
   output logic                         wb_rty_o,
   output logic                         mem_req,
   input  logic                         mem_gnt,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic                         mem_we,
   output logic [3:0]                   mem_be,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata,
   input  logic                         mem_rvalid
);

   localparam int AW = $clog2(MEM_WORDS);

   state_t         state;
   state_t         state_n;
   logic [AW-1:0]  base_q;
   logic [1:0]     beat;
   logic [15:0]    sel_q;
   logic           we_q;
   logic [127:0]   wdat_q;
   logic [127:0]   rdat_q;
   logic           aborted;
   logic [31:0]    off;
   logic           bad;
   logic           accept;
   logic           timeout;
   logic [2:0]     nxt;
   logic [2:0]     first;

   assign off   = wb_adr_i - MEM_BASE;
   assign bad   = (wb_adr_i[3:0] != 4'h0) || (wb_adr_i < MEM_BASE)
                  || (off >= 32'(4 * MEM_WORDS));
   assign first = next_lane(wb_sel_i, 3'd0);
   assign nxt   = next_lane(sel_q, {1'b0, beat} + 3'd1);

`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
   bridge_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .active (state == ISSUE || state == WAIT),
      .clear  ((state == ISSUE && mem_gnt) || (state == WAIT && mem_rvalid)),
      .timeout(timeout)
   );
`else
   // No watchdog: a stalled memory is waited on forever.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      accept   = 1'b0;
      mem_req  = 1'b0;
      wb_ack_o = 1'b0;
      wb_err_o = 1'b0;
      unique case (state)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               accept = 1'b1;
               if (bad)
                  state_n = ERR;
               else if (wb_sel_i == 16'h0)
                  state_n = DONE;
               else
                  state_n = ISSUE;
            end
         end
         ISSUE: begin
            mem_req = 1'b1;
            if (timeout)
               state_n = wb_cyc_i ? ERR : IDLE;
            else if (mem_gnt) begin
               if (!we_q)
                  state_n = WAIT;
               else if (!wb_cyc_i)
                  state_n = IDLE;
               else if (nxt[2])
                  state_n = DONE;
            end else if (!wb_cyc_i)
               state_n = IDLE;
         end
         WAIT: begin
            // An abandoned read still owns the memory until its data returns.
            if (timeout)
               state_n = (wb_cyc_i && !aborted) ? ERR : IDLE;
            else if (mem_rvalid) begin
               if (aborted || !wb_cyc_i)
                  state_n = IDLE;
               else if (nxt[2])
                  state_n = DONE;
               else
                  state_n = ISSUE;
            end
         end
         DONE: begin
            wb_ack_o = 1'b1;
            state_n  = IDLE;
         end
         ERR: begin
            wb_err_o = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q  <= '0;
         beat    <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         aborted <= 1'b0;
      end else begin
         if (accept) begin
            base_q  <= off[AW+1:2];
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            wdat_q  <= wb_dat_i;
            rdat_q  <= '0;
            aborted <= 1'b0;
            beat    <= first[1:0];
         end
         if (state == ISSUE && mem_gnt && we_q && !nxt[2])
            beat <= nxt[1:0];
         if (state == WAIT && mem_rvalid) begin
            if (!aborted && wb_cyc_i)
               rdat_q[int'(beat)*LANE_W +: LANE_W] <= mem_rdata;
            if (!nxt[2])
               beat <= nxt[1:0];
         end
         if ((state == ISSUE || state == WAIT) && !wb_cyc_i)
            aborted <= 1'b1;
      end
   end

   assign mem_addr  = mem_req ? base_q + AW'(beat) : '0;
   assign mem_we    = mem_req & we_q;
   assign mem_be    = mem_req ? sel_q[int'(beat)*4 +: 4] : 4'h0;
   assign mem_wdata = mem_req ? wdat_q[int'(beat)*LANE_W +: LANE_W] : '0;
   assign wb_dat_o  = wb_ack_o ? rdat_q : '0;
   assign wb_rty_o  = 1'b0;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Randomised scoreboard bench for wb_sram_bridge with a behavioural
// line-memory model and a stalling SRAM responder.
module tb_wb_sram_bridge;

   localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
   localparam int          MEM_WORDS = 16384;
   localparam int          TMO       = 8;
   localparam int          AW        = $clog2(MEM_WORDS);

   logic           clk = 1'b0;
   logic           rst;
   logic [31:0]    wb_adr_i;
   logic [127:0]   wb_dat_i;
   logic [127:0]   wb_dat_o;
   logic           wb_we_i;
   logic [15:0]    wb_sel_i;
   logic           wb_stb_i;
   logic           wb_cyc_i;
   logic           wb_ack_o;
   logic           wb_err_o;
   logic           wb_rty_o;
   logic           mem_req;
   logic           mem_gnt;
   logic [AW-1:0]  mem_addr;
   logic           mem_we;
   logic [3:0]     mem_be;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;
   logic           mem_rvalid;

   wb_sram_bridge #(
      .MEM_BASE      (MEM_BASE),
      .MEM_WORDS     (MEM_WORDS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_dat_o  (wb_dat_o),
      .wb_we_i   (wb_we_i),
      .wb_sel_i  (wb_sel_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .wb_rty_o  (wb_rty_o),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           err;
      logic [127:0] dat;
   } resp_t;

   typedef struct {
      int          addr;
      bit          we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } beat_t;

   resp_t       exp_q[$];
   beat_t       beat_q[$];
   logic [31:0] sram    [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];

   int checks     = 0;
   int failures   = 0;
   int terms_seen = 0;
   bit rand_mode  = 1'b0;
   bit block_gnt  = 1'b0;
   int hold_addr  = -1;
   int hold_len   = 0;
   int det_rd_dly = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line-level reference: mode 0 = beats only, 1 = normal, 2 = forced err.
   task automatic model(input logic [31:0] adr, input bit we,
                        input logic [15:0] sel, input logic [127:0] dat,
                        input int mode);
      resp_t      r;
      beat_t      b;
      longint     off;
      bit         bad;
      int         w;
      logic [3:0] nib;
      off   = longint'(adr) - longint'(MEM_BASE);
      bad   = (adr[3:0] != 4'h0) || off < 0 || off >= 4 * MEM_WORDS;
      r.err = bad || mode == 2;
      r.dat = '0;
      if (!bad) begin
         w = int'(off / 4);
         for (int n = 0; n < 4; n++) begin
            nib = sel[4*n +: 4];
            if (nib != 4'h0) begin
               b.addr  = w + n;
               b.we    = we;
               b.be    = nib;
               b.wdata = dat[32*n +: 32];
               beat_q.push_back(b);
               if (we) begin
                  for (int k = 0; k < 4; k++)
                     if (nib[k]) ref_mem[w+n][8*k +: 8] = dat[32*n+8*k +: 8];
               end else begin
                  r.dat[32*n +: 32] = ref_mem[w+n];
               end
            end
         end
      end
      if (r.err) r.dat = '0;
      if (mode != 0) exp_q.push_back(r);
   endtask

   // SRAM responder: grants, stalls, returns read data, checks each beat.
   initial begin
      bit          rd_pend;
      bit          pend_before;
      bit          in_req;
      int          rd_dly;
      int          stall;
      int          rd_addr;
      bit          ok;
      beat_t       b;
      rd_pend = 0; in_req = 0; rd_dly = 0; stall = 0; rd_addr = 0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         pend_before = rd_pend;
         if (rd_pend && rd_dly == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = sram[rd_addr];
            rd_pend    = 0;
         end else begin
            if (rd_pend) rd_dly--;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
         end
         mem_gnt = 1'b0;
         if (mem_req) begin
            if (beat_q.size() == 0) begin
               chk(1'b0, "unexpected_req", 128'(mem_addr), 128'(0));
            end else begin
               b  = beat_q[0];
               ok = int'(mem_addr) == b.addr && mem_we == b.we
                    && mem_be == b.be && (!b.we || mem_wdata == b.wdata);
               chk(ok, "beat", {mem_we, mem_be, mem_addr, mem_wdata},
                   {b.we, b.be, AW'(b.addr), b.wdata});
            end
            chk(!pend_before, "outstanding", 128'(pend_before), 128'(0));
            if (!in_req) begin
               in_req = 1;
               stall  = rand_mode ? int'($urandom_range(0, 2))
                      : (int'(mem_addr) == hold_addr ? hold_len : 0);
            end
            if (block_gnt) begin
               in_req = 1;
            end else if (stall > 0) begin
               stall--;
            end else begin
               mem_gnt = 1'b1;
               in_req  = 0;
               if (beat_q.size() > 0) void'(beat_q.pop_front());
               if (mem_we) begin
                  for (int k = 0; k < 4; k++)
                     if (mem_be[k]) sram[mem_addr][8*k +: 8] = mem_wdata[8*k +: 8];
               end else begin
                  rd_pend = 1;
                  rd_addr = int'(mem_addr);
                  rd_dly  = rand_mode ? int'($urandom_range(0, 3)) : det_rd_dly;
               end
            end
         end else begin
            in_req = 0;
         end
      end
   end

   // Termination monitor.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst && (wb_ack_o || wb_err_o)) begin
            terms_seen++;
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_term", {wb_ack_o, wb_err_o}, 128'(0));
            end else begin
               r = exp_q.pop_front();
               chk(wb_err_o == r.err && wb_ack_o == !r.err && !wb_rty_o,
                   "term_kind", {wb_rty_o, wb_ack_o, wb_err_o},
                   {1'b0, !r.err, r.err});
               chk(wb_dat_o === r.dat, "rdata", wb_dat_o, r.dat);
            end
         end
      end
   end

   task automatic wb_xfer(input logic [31:0] adr, input bit we,
                          input logic [15:0] sel, input logic [127:0] dat,
                          input int exp_lat, input int mode);
      int lat;
      lat = 0;
      model(adr, we, sel, dat, mode);
      @(negedge clk);
      wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      do begin
         @(negedge clk);
         lat++;
      end while (!(wb_ack_o || wb_err_o) && lat < 500);
      if (!(wb_ack_o || wb_err_o)) begin
         chk(1'b0, "wb_timeout", 128'(lat), 128'(0));
         exp_q.delete();
         beat_q.delete();
      end else if (exp_lat >= 0) begin
         chk(lat == exp_lat, "latency", 128'(lat), 128'(exp_lat));
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   task automatic wb_abort(input logic [31:0] adr, input bit we,
                           input logic [15:0] sel, input logic [127:0] dat,
                           input int cycles);
      model(adr, we, sel, dat, 0);
      @(negedge clk);
      wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      repeat (cycles) @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [127:0] d;
      logic [31:0]  adr;
      logic [15:0]  sel;
      int           n;
      int           kind;
      rst = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
         ref_mem[i] = $urandom;
         sram[i]    = ref_mem[i];
      end
      repeat (3) @(negedge clk);
      chk({wb_ack_o, wb_err_o, wb_rty_o} == 3'b000, "rst_wb",
          {wb_ack_o, wb_err_o, wb_rty_o}, 128'(0));
      chk(wb_dat_o == '0, "rst_dat", wb_dat_o, 128'(0));
      chk({mem_req, mem_we, mem_be, mem_addr, mem_wdata} == '0, "rst_mem",
          {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 128'(0));
      rst = 1'b1;

      wb_xfer(32'h10, 1'b1, 16'hFFFF,
              128'h44444444_33333333_22222222_11111111, 5, 1);
      sram[1] = 32'hDEADBEEF;
      ref_mem[1] = 32'hDEADBEEF;
      wb_xfer(32'h0, 1'b0, 16'h00F0, '0, 3, 1);
      wb_xfer(32'h10, 1'b0, 16'hFFFF, '0, 9, 1);
      wb_xfer(32'h4, 1'b0, 16'hFFFF, '0, 1, 1);
      wb_xfer(MEM_BASE + 32'(4 * MEM_WORDS), 1'b1, 16'hFFFF, '1, 1, 1);
      wb_xfer(32'h20, 1'b1, 16'h0000, '1, 1, 1);

      hold_addr = 10;
      hold_len  = 3;
      d = {$urandom, $urandom, $urandom, $urandom};
      wb_xfer(32'h20, 1'b1, 16'hFFFF, d, 8, 1);
      hold_addr = -1;
      wb_xfer(32'h20, 1'b0, 16'hFFFF, '0, 9, 1);

      det_rd_dly = 4;
      n = terms_seen;
      wb_abort(32'h10, 1'b0, 16'h000F, '0, 2);
      repeat (3) @(negedge clk);
      chk(terms_seen == n, "abort_no_ack", 128'(terms_seen), 128'(n));
      beat_q.delete();
      det_rd_dly = 0;
      wb_xfer(32'h10, 1'b0, 16'hFFFF, '0, -1, 1);

      block_gnt = 1'b1;
`ifdef WB_SRAM_BRIDGE_TIMEOUT_EN
      wb_xfer(32'h30, 1'b0, 16'hFFFF, '0, TMO + 1, 2);
      beat_q.delete();
`else
      n = terms_seen;
      wb_abort(32'h30, 1'b0, 16'hFFFF, '0, 100);
      chk(mem_req == 1'b1, "still_waiting", 128'(mem_req), 128'(1));
      chk(terms_seen == n, "no_term", 128'(terms_seen), 128'(n));
      @(negedge clk);
      beat_q.delete();
`endif
      @(negedge clk);

      model(32'h40, 1'b0, 16'hFFFF, '0, 0);
      wb_adr_i = 32'h40; wb_we_i = 1'b0; wb_sel_i = 16'hFFFF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk(mem_req == 1'b0, "reset_drops_req", 128'(mem_req), 128'(0));
      @(negedge clk);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      rst = 1'b1;
      beat_q.delete();
      block_gnt = 1'b0;

      rand_mode = 1'b1;
      repeat (200) begin
         kind = int'($urandom_range(0, 9));
         adr  = 32'($urandom_range(0, 31)) * 32'd16;
         if (kind == 0)
            adr = adr + 32'($urandom_range(1, 15));
         else if (kind == 1)
            adr = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 1000)) * 32'd16;
         case ($urandom_range(0, 7))
            0:       sel = 16'h0000;
            1:       sel = 16'hFFFF;
            default: sel = 16'($urandom);
         endcase
         d = {$urandom, $urandom, $urandom, $urandom};
         wb_xfer(adr, 1'($urandom), sel, d, -1, 1);
      end

      repeat (5) @(negedge clk);
      chk(exp_q.size() == 0, "drain", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_sram_bridge.md
# wb_sram_bridge

Wishbone B4 classic slave bridging the CPU core's 128-bit line bus (wb_*) to a 32-bit single-port SRAM-style memory. Each 128-bit transfer is split into up to four 32-bit beats, which are issued serially with one memory access outstanding at a time. The block sits directly downstream of the core's wishbone master port and terminates every cycle with exactly one ack or err.

## Interface
- MEM_BASE, 32'h0000_0000: byte base address of the decoded window.
- MEM_WORDS, 16384: size of the window in 32-bit words; power of two.
- TIMEOUT_CYCLES, 255: watchdog limit; used only when the watchdog is compiled in.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_adr_i  in  32  byte address of the 128-bit line; bits [3:0] must be 0.
- wb_dat_i  in  128  write data; lane n = bits [32n+31:32n], at word address +n.
- wb_dat_o  out  128  read data.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  16  byte enables; nibble n selects lane n.
- wb_stb_i, wb_cyc_i  in  1 each  classic strobe and cycle.
- wb_ack_o, wb_err_o, wb_rty_o  out  1 each  terminations; wb_rty_o is tied 0.
- mem_req  out  1  beat request.
- mem_gnt  in  1  memory accepts the request in this cycle.
- mem_addr  out  $clog2(MEM_WORDS)  word address.
- mem_we  out  1  write beat.
- mem_be  out  4  byte enables for the beat.
- mem_wdata  out  32  write data for the beat.
- mem_rdata  in  32  read data, valid while mem_rvalid is high.
- mem_rvalid  in  1  read data return, at least 1 cycle after the grant.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: when wb_cyc_i & wb_stb_i & !ack/err, latch the address, sel, we and data.
  - If the address is misaligned, or outside [MEM_BASE, MEM_BASE + 4*MEM_WORDS), go to ERR.
  - Otherwise, if sel == 0, go to DONE.
  - Otherwise go to ISSUE with beat = lowest lane whose nibble is nonzero.
- ISSUE:
  - Drive mem_req, mem_addr = ((adr - MEM_BASE) >> 2) + beat, mem_be = sel nibble, and the lane data; hold these stable until mem_gnt.
  - On grant of a read, go to WAIT.
  - On grant of a write, advance to the next enabled lane, or go to DONE if none remains.
- WAIT: on mem_rvalid, store mem_rdata in the lane, then go to the next enabled lane (ISSUE) or DONE.
- Lanes with a zero sel nibble are never accessed; reads return 0 in those lanes.
- DONE: assert wb_ack_o for exactly one cycle with wb_dat_o valid, then go to IDLE.
- ERR: assert wb_err_o for exactly one cycle, then go to IDLE. wb_dat_o = 0.
- Abort (wb_cyc_i falls outside IDLE):
  - An ungranted request is withdrawn.
  - A pending read still waits for mem_rvalid; its data is discarded.
  - Then return to IDLE with no ack.
- Reset values: all outputs 0, state IDLE, beat 0, wb_dat_o 0. Reset mid-transfer drops mem_req immediately; any later mem_rvalid is ignored.

## Timing
- Cycle 0 is the cycle in which the strobe is sampled in IDLE.
- Full write with mem_gnt constantly high: mem_req in cycles 1–4, wb_ack_o in cycle 5.
- Full read with 1-cycle rvalid: req in cycles 1, 3, 5, 7; rvalid in cycles 2, 4, 6, 8; ack in cycle 9.
- Error or sel == 0: err/ack in cycle 1, with no mem_req.
- After ack/err, the earliest next strobe is accepted in the following cycle.
- At most one outstanding memory access at all times.

## Configuration
- WB_SRAM_BRIDGE_TIMEOUT_EN defined:
  - A watchdog counts the cycles spent in ISSUE/WAIT without mem_gnt or mem_rvalid respectively.
  - When it reaches TIMEOUT_CYCLES, it drops mem_req and enters ERR.
  - The counter clears on every grant or rvalid.
- Not defined: no counter; the bridge waits indefinitely.

## Structure
- Package wb_bridge_pkg: state enum, LANES = 4, LANE_W = 32, and the lane-select helper function.
- Sub-module bridge_watchdog (counter, clear, timeout flag), instantiated only under WB_SRAM_BRIDGE_TIMEOUT_EN.

## Test plan
- Write of line 32'h10 with sel = 16'hFFFF and data = 128'h4444…_1111… -> four beats at addr 4..7, be = 4'hF, ack at cycle 5.
- Read with sel = 16'h00F0, memory returning 32'hDEADBEEF at addr 1 -> a single beat; wb_dat_o = 128'h0…_DEADBEEF_0000_0000.
- adr = 32'h4 (misaligned), then adr = MEM_BASE + 4*MEM_WORDS -> each gives wb_err_o at cycle 1, with no mem_req.
- mem_gnt withheld for 3 cycles on beat 2 -> mem_addr, mem_wdata and mem_be stay stable; the ack is delayed by exactly 3 cycles.
- wb_cyc_i dropped while in WAIT -> no ack; the bridge absorbs the late rvalid, and the next read completes correctly.
- With WB_SRAM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_gnt held 0 -> wb_err_o in the 9th cycle of ISSUE; without the macro, still waiting after 100 cycles.
